// File: rtl/rr_index_encoder.sv
// Round-robin request-to-index encoder: picks one requester starting from a
// rotating pointer and holds the resulting index/one-hot under valid/ready.
//
// state | meaning
// IDLE  | no grant outstanding; arbitrate when en_i=1 and req_i!=0
// GRANT | grant held stable until grant_ready_i accepts it
module rr_index_encoder #(
  parameter int N    = 32,
  parameter int IDXW = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  input  logic            grant_ready_i,
  output logic            grant_valid_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic [N-1:0]    grant_onehot_o,
  output logic            busy_o
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  localparam logic [N-1:0]    ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDXW-1:0] ONE_IDX = {{(IDXW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    onehot_q, onehot_d;

  logic            sel_found;
  logic [IDXW-1:0] sel_idx;

  // Scan offsets 0..N-1 from ptr; the IDXW-bit add gives the modulo-N wrap.
  always_comb begin
    logic [IDXW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + k[IDXW-1:0];
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        if (en_i && sel_found) begin
          state_d  = GRANT;
          idx_d    = sel_idx;
          onehot_d = ONE_N << sel_idx;
        end
      end
      GRANT: begin
        if (grant_ready_i) begin
          state_d  = IDLE;
          ptr_d    = idx_q + ONE_IDX;
          idx_d    = '0;
          onehot_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        idx_d    = '0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign grant_valid_o  = (state_q == GRANT);
  assign busy_o         = (state_q == GRANT);
  assign grant_idx_o    = idx_q;
  assign grant_onehot_o = onehot_q;

  a_onehot_matches_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
    grant_onehot_o == (grant_valid_o ? (ONE_N << grant_idx_o) : '0));
  a_busy_is_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o == grant_valid_o);

endmodule

// File: tb/tb_rr_index_encoder.sv
// Directed bench for rr_index_encoder: reset, fairness sweep, rotation,
// backpressure hold, enable gating and asynchronous reset mid-grant.
module tb_rr_index_encoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [31:0] req_i;
  logic        grant_ready_i;
  logic        grant_valid_o;
  logic [4:0]  grant_idx_o;
  logic [31:0] grant_onehot_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  rr_index_encoder #(.N(32), .IDXW(5)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .req_i          (req_i),
    .grant_ready_i  (grant_ready_i),
    .grant_valid_o  (grant_valid_o),
    .grant_idx_o    (grant_idx_o),
    .grant_onehot_o (grant_onehot_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [4:0] idx);
    chk({tag, "_valid"}, 32'(grant_valid_o), 32'd1);
    chk({tag, "_idx"}, 32'(grant_idx_o), 32'(idx));
    chk({tag, "_onehot"}, grant_onehot_o, 32'd1 << idx);
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(grant_valid_o), 32'd0);
    chk({tag, "_idx"}, 32'(grant_idx_o), 32'd0);
    chk({tag, "_onehot"}, grant_onehot_o, 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    en_i          = 1'b1;
    req_i         = 32'hFFFF_FFFF;
    grant_ready_i = 1'b0;

    // reset held with all requests pending
    repeat (3) step();
    chk_idle("reset");
    rst_ni = 1'b1;
    step();
    chk_grant("first", 5'd0);

    // fairness sweep 0..31 then wrap to 0, one grant every 2 cycles
    grant_ready_i = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      chk_grant($sformatf("fair%0d", i), 5'(i % 32));
      step();
      chk_idle($sformatf("bubble%0d", i));
      if (i < 32) step();
    end
    req_i         = 32'h0;
    grant_ready_i = 1'b0;
    step();
    chk_idle("norequest");

    // rotation: get ptr to 5, then wrap past 31 to bit 0
    req_i = 32'h0000_0010;
    step();
    chk_grant("setptr", 5'd4);
    grant_ready_i = 1'b1;
    req_i = 32'h0000_0011;
    step();
    grant_ready_i = 1'b0;
    step();
    chk_grant("rot_wrap", 5'd0);
    grant_ready_i = 1'b1;
    req_i = 32'h0000_0012;
    step();
    grant_ready_i = 1'b0;
    step();
    chk_grant("rot_next", 5'd1);
    grant_ready_i = 1'b1;
    req_i = 32'h0000_0080;
    step();

    // backpressure: idx 7 held while req changes and drops
    grant_ready_i = 1'b0;
    step();
    chk_grant("bp_issue", 5'd7);
    req_i = 32'h8000_0000;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) req_i = 32'h0;
      step();
      chk_grant($sformatf("bp_hold%0d", c), 5'd7);
    end
    req_i = 32'h8000_0000;
    grant_ready_i = 1'b1;
    step();
    chk_idle("bp_accept");
    grant_ready_i = 1'b0;
    step();
    chk_grant("bp_next", 5'd31);
    grant_ready_i = 1'b1;
    req_i = 32'h0;
    step();
    chk_idle("bp_done");

    // enable gating; grant_ready in IDLE is ignored
    en_i  = 1'b0;
    req_i = 32'h0000_0100;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_idle($sformatf("en_off%0d", c));
    end
    grant_ready_i = 1'b0;
    en_i = 1'b1;
    step();
    chk_grant("en_on", 5'd8);
    en_i = 1'b0;
    repeat (3) step();
    chk_grant("en_drop", 5'd8);
    en_i = 1'b1;
    grant_ready_i = 1'b1;
    req_i = 32'h0000_1000;
    step();

    // asynchronous reset while idx 12 is granted
    grant_ready_i = 1'b0;
    step();
    chk_grant("pre_rst", 5'd12);
    #3;
    rst_ni = 1'b0;
    #1;
    chk_idle("async_rst");
    @(posedge clk_i);
    #1;
    req_i  = 32'h0000_1001;
    rst_ni = 1'b1;
    step();
    chk_grant("post_rst", 5'd0);
    grant_ready_i = 1'b1;
    step();
    grant_ready_i = 1'b0;
    step();
    chk_grant("post_rst_next", 5'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_index_encoder.md
Name: rr_index_encoder

Overview:
- Round-robin request-to-index encoder. It is the inverse of the register-file write-select decoder: a 32-bit request vector goes in, and a 5-bit index plus a one-hot echo of that index come out.
- Used wherever several sources compete for one register-file write port or shared resource.
- The selected index is held under a valid/ready handshake until the consumer accepts it.
- A rotating priority pointer guarantees fairness.

Parameters:
- N, 32, number of request lines. Must be a power of two, minimum 2.
- IDXW, 5, index width. Must equal log2(N).

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset. Assertion is immediate; release is synchronous to clk.
- en  input  1  arbitration enable. Gates only the start of a new arbitration.
- req  input  N  request vector; bit i set means source i requests.
- grant_ready  input  1  consumer accepts the current grant.
- grant_valid  output  1  grant_idx and grant_onehot are valid.
- grant_idx  output  IDXW  index of the granted source.
- grant_onehot  output  N  one-hot of grant_idx. Exactly one bit set while grant_valid=1, all zero otherwise.
- busy  output  1  high whenever the state machine is in GRANT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0.
  - grant_valid=0, grant_idx=0, grant_onehot=0, busy=0.
  - Reset mid-grant discards the grant; ptr returns to 0.
- State IDLE:
  - On each edge, if en=1 and req is non-zero, select the first set bit of req searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Register that bit's index into grant_idx and its one-hot into grant_onehot.
  - Set grant_valid=1 and go to GRANT.
  - Latency: grant_valid rises on the edge that samples req, so it is visible 1 cycle after req is presented.
  - If en=0 or req=0: stay in IDLE, outputs unchanged at zero.
- State GRANT:
  - grant_idx, grant_onehot and grant_valid are held stable.
  - Changes to req, or req dropping to zero, do not withdraw or alter the grant.
  - en has no effect in this state.
  - On an edge with grant_ready=1:
    - ptr <= (grant_idx+1) mod N; index N-1 wraps to 0.
    - grant_valid, grant_idx and grant_onehot clear to 0.
    - State returns to IDLE.
  - Throughput: at most one grant per 2 cycles. One mandatory IDLE bubble follows each accept.
  - grant_ready=1 while in IDLE is ignored.
- Pointer and index arithmetic:
  - ptr is IDXW bits and wraps naturally modulo N.
  - Search offsets are computed modulo N, with no out-of-range indices.
  - When req has a single bit set, that bit is granted regardless of ptr.
- Invariants, checked by assertions:
  - grant_onehot == (grant_valid ? 1<<grant_idx : 0).
  - busy == grant_valid.
- Implementation: purely synchronous apart from the reset. No combinational path from req or grant_ready to any output.

Test Plan:
- Reset with rst_n=0 while req=32'hFFFF_FFFF and en=1 → all outputs stay 0. After release, the first grant is idx 0 with onehot 32'h1.
- Fairness with req=32'hFFFF_FFFF held and grant_ready=1 continuously → grant_idx sequence 0,1,2,…,31,0, one grant every 2 cycles. The wrap from 31 to 0 is observed.
- Rotating priority: with ptr=5, req=32'h0000_0011 (bits 0 and 4) → grant idx 0 after wrap. Next, req=32'h0000_0012 → idx 1.
- Hold under backpressure: grant idx 7 issued, then grant_ready=0 for 10 cycles while req changes to 32'h8000_0000 → idx 7 and onehot 32'h80 held, busy=1 throughout. Accept, then the next grant is idx 31.
- Enable gating: en=0 with req=32'h0000_0100 → no grant for 5 cycles. Raise en → grant_valid=1 the next cycle with idx 8. Dropping en during GRANT does not clear the grant.
- Async reset mid-grant: assert rst_n=0 between edges while grant_valid=1 and idx=12 → outputs clear immediately. After release, req=32'h0000_1001 grants idx 0 (ptr=0).
